// File: rtl/mod_74x165_tx.sv
// 74x165-style parallel-in/serial-out transmitter.
// A word is loaded over a valid/ready handshake and shifted out MSB first,
// one bit per non-inhibited clock. A one-cycle LATCH pulse follows the last
// bit so a downstream 74x595-style receiver can transfer its shift register.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | READY high; SR holds, so QH keeps the last shifted value
// ST_SHIFT | frame in flight; one bit consumed per edge with CLK_INH low
// ST_LATCH | single cycle with LATCH high; then back to ST_IDLE
module mod_74x165_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  input  logic             SER,
  input  logic             CLK_INH,
  output logic             QH,
  output logic             QH_N,
  output logic             BIT_STB,
  output logic             LATCH,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             latch_q, latch_d;
  logic             shift_q, shift_d;

  // Next-state decode; status flags are derived from the next state so they
  // can be registered alongside it and never depend on VALID or D directly.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (VALID) begin
          sr_d    = D;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!CLK_INH) begin
          sr_d = {sr_q[WIDTH-2:0], SER};
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_LATCH;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    latch_d = (state_d == ST_LATCH);
    shift_d = (state_d == ST_SHIFT);
  end

  // State, shift register, bit counter and registered status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      latch_q <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      latch_q <= latch_d;
      shift_q <= shift_d;
    end
  end

  // An inhibited cycle holds the current bit, so it must not be strobed.
  assign BIT_STB = shift_q & ~CLK_INH;
  assign READY   = ready_q;
  assign BUSY    = ~ready_q;
  assign LATCH   = latch_q;
  assign QH      = sr_q[WIDTH-1];
  assign QH_N    = ~sr_q[WIDTH-1];

endmodule

// File: doc/mod_74x165_tx.md
Name: mod_74x165_tx

Overview:
8-bit (parameterizable) parallel-in/serial-out transmitter built around a 74x165-style shift register. It is the sending end for the serial-in/parallel-out receivers (74x164/74x595 models). It accepts a parallel word over a valid/ready handshake and shifts it out MSB first, one bit per non-inhibited clock. After the last bit it emits a one-cycle LATCH pulse to drive a downstream register-clock input.

Parameters:
WIDTH, 8, shift register length in bits (legal range WIDTH >= 2)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
D  input  WIDTH  parallel load word; D[WIDTH-1] is transmitted first
VALID  input  1  D is valid; a load is accepted when VALID & READY at a rising edge
READY  output  1  high only in IDLE; transmitter can accept a word
SER  input  1  serial cascade input, shifted into bit 0 on every shift
CLK_INH  input  1  clock inhibit; when high, SHIFT holds all state
QH  output  1  serial data out = SR[WIDTH-1]
QH_N  output  1  always ~QH
BIT_STB  output  1  high while QH carries a frame bit that will be consumed at the next edge
LATCH  output  1  one-cycle pulse after the final bit
BUSY  output  1  high in SHIFT and LATCH (equals ~READY)

Behaviour:
- State: SR[WIDTH-1:0], bit counter CNT (clog2(WIDTH) bits), FSM with states IDLE, SHIFT, LATCH.
- RST high (async, any time, including mid-frame): SR=0, CNT=0, state=IDLE. Outputs: QH=0, QH_N=1, READY=1, BUSY=0, BIT_STB=0, LATCH=0. An aborted frame produces no LATCH.
- IDLE:
  - READY=1, BIT_STB=0. SR holds its value, so QH shows the last shifted value.
  - VALID at an edge: SR<=D, CNT<=0, go to SHIFT. CLK_INH is ignored for the load.
  - VALID low: remain in IDLE.
- SHIFT:
  - BIT_STB = ~CLK_INH.
  - Edge with CLK_INH=0: SR<={SR[WIDTH-2:0],SER}, CNT<=CNT+1. If CNT==WIDTH-1, go to LATCH and set CNT<=0.
  - Edge with CLK_INH=1: SR, CNT and state all hold.
  - VALID is ignored (READY=0).
- LATCH: LATCH=1, BIT_STB=0, READY=0 for exactly one cycle; CLK_INH is ignored. Go to IDLE on the next edge.
- Timing with no inhibit, load accepted at edge E0:
  - Bit k (MSB = bit 0 of the frame) appears on QH during cycle k+1 with BIT_STB=1.
  - LATCH is high in cycle WIDTH+1.
  - READY is high again in cycle WIDTH+2.
  - Minimum frame period is WIDTH+2 cycles; there is no load during LATCH.
- Inhibit: each inhibited cycle in SHIFT stretches the frame by one cycle. The bit on QH is unchanged and BIT_STB=0 for that cycle.
- Cascade: after a full frame SR holds the WIDTH SER samples taken at the shift edges, oldest sample in the MSB.
- BIT_STB, READY, BUSY and LATCH are decoded from registered state plus CLK_INH only. There is no combinational path from VALID or D to any output.

Test Plan:
- Assert RST for 2 cycles with VALID=1, D=8'hFF -> QH=0, QH_N=1, READY=1, BUSY=0, LATCH=0, BIT_STB=0; after release, first edge with VALID loads.
- Load D=8'hA5 with SER=0 and CLK_INH=0 -> QH over BIT_STB cycles 1..8 is 1,0,1,0,0,1,0,1; LATCH=1 only in cycle 9; READY=1 in cycle 10; QH=0 in IDLE.
- Load 8'h81 and hold CLK_INH=1 for 3 cycles after bit 2 -> QH stays at bit 2 with BIT_STB=0 for those 3 cycles; the sequence is 1,0,0,0,0,0,0,1; LATCH in cycle 12.
- During SHIFT, drive VALID=1 with D=8'h3C every cycle -> frame bits are unaffected, the new word is accepted only on the first edge with READY=1, and the back-to-back period is 10 cycles.
- Load 8'hF0 and assert RST asynchronously (mid-cycle) after bit 4 -> outputs go to reset values before the next edge, no LATCH is pulsed, and READY=1.
- Load 8'h00 with SER=1 constant -> 8 zeros are sent; in the following IDLE QH=1; a second frame loaded with 8'hFF sends all ones.
